// File: rtl/game_pkg.sv
// Shared definitions for the game-flow controller and its display mux.
package game_pkg;

  // Encodings are fixed so the display mux can decode the raw state bits.
  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_PLAYING   = 2'b01,
    S_GAME_OVER = 2'b10,
    S_PAUSED    = 2'b11
  } state_e;

  localparam int unsigned BCD_W       = 4;
  localparam int unsigned MAX_PLAYERS = 4;
  localparam int unsigned LIVES_W     = 4;
  localparam int unsigned TIME_W      = 8;
  localparam int unsigned WIN_W       = 2;

endpackage

// File: rtl/game_ctrl_bcd_counter.sv
// Saturating multi-digit BCD up-counter with synchronous clear.
module bcd_counter
  import game_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    inc,
  output logic [DIGITS*BCD_W-1:0] value,
  output logic [DIGITS*BCD_W-1:0] next_c,
  output logic                    full_c
);

  logic carry;

  // Flag when every digit already reads 9.
  always_comb begin
    full_c = 1'b1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (value[d*BCD_W +: BCD_W] != 4'd9) full_c = 1'b0;
    end
  end

  // Ripple the increment through the digits, stopping at all-9s.
  always_comb begin
    next_c = value;
    carry  = 1'b0;
    if (clr) begin
      next_c = '0;
    end else if (inc && !full_c) begin
      carry = 1'b1;
      for (int unsigned d = 0; d < DIGITS; d++) begin
        if (carry) begin
          if (value[d*BCD_W +: BCD_W] == 4'd9) begin
            next_c[d*BCD_W +: BCD_W] = 4'd0;
          end else begin
            next_c[d*BCD_W +: BCD_W] = value[d*BCD_W +: BCD_W] + 4'd1;
            carry                    = 1'b0;
          end
        end
      end
    end
  end

  // Score register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value <= '0;
    else        value <= next_c;
  end

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: state machine, per-player scores/lives, round timer.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS    = 2,
  parameter int unsigned SCORE_DIGITS   = 2,
  parameter int unsigned MAX_LIVES      = 3,
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned ROUND_SECONDS  = 99
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  frame,
  input  logic                                  start,
  input  logic                                  pause,
  input  logic [NUM_PLAYERS-1:0]                hit,
  input  logic [NUM_PLAYERS-1:0]                miss,
  output logic [1:0]                            state,
  output logic [NUM_PLAYERS*SCORE_DIGITS*4-1:0] score,
  output logic [NUM_PLAYERS*4-1:0]              lives,
  output logic [NUM_PLAYERS-1:0]                alive,
  output logic [7:0]                            time_left,
  output logic [1:0]                            winner,
  output logic                                  tie
);

  localparam int unsigned SW  = SCORE_DIGITS * BCD_W;
  localparam int unsigned FCW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  state_e state_q, state_d;

  logic [FCW-1:0]             fcnt_q, fcnt_d;
  logic [TIME_W-1:0]          time_d;
  logic [NUM_PLAYERS*4-1:0]   lives_d;
  logic [NUM_PLAYERS-1:0]     alive_d;
  logic [WIN_W-1:0]           winner_d;
  logic                       tie_d;

  logic                       playing;
  logic                       clr;
  logic                       sec_tick;
  logic                       game_end;
  logic [NUM_PLAYERS-1:0]     inc;
  logic [NUM_PLAYERS-1:0]     full;
  logic [SW-1:0]              nxt_score [NUM_PLAYERS];

  logic [SW-1:0]              best;
  logic [WIN_W-1:0]           win_c;
  logic                       tie_c;

  assign state   = state_q;
  assign playing = (state_q == S_PLAYING);
  assign clr     = (state_q == S_IDLE) || ((state_q == S_GAME_OVER) && start);

  // One saturating BCD score counter per player.
  for (genvar g = 0; g < int'(NUM_PLAYERS); g++) begin : g_score
    assign inc[g] = playing && hit[g] && alive[g] && !full[g];
    bcd_counter #(.DIGITS(SCORE_DIGITS)) u_score (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .inc    (inc[g]),
      .value  (score[g*SW +: SW]),
      .next_c (nxt_score[g]),
      .full_c (full[g])
    );
  end

  // Frame divider, round timer and lives bookkeeping for the coming edge.
  always_comb begin
    fcnt_d   = fcnt_q;
    time_d   = time_left;
    lives_d  = lives;
    alive_d  = alive;
    sec_tick = 1'b0;
    if (clr) begin
      fcnt_d = '0;
      time_d = TIME_W'(ROUND_SECONDS);
      for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
        lives_d[i*LIVES_W +: LIVES_W] = LIVES_W'(MAX_LIVES);
      end
      alive_d = '1;
    end else if (playing) begin
      if (frame) begin
        if (fcnt_q == FCW'(FRAMES_PER_SEC - 1)) begin
          fcnt_d   = '0;
          sec_tick = 1'b1;
          time_d   = time_left - 8'd1;
        end else begin
          fcnt_d = fcnt_q + FCW'(1);
        end
      end
      for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
        if (miss[i] && (lives[i*LIVES_W +: LIVES_W] != 4'd0)) begin
          lives_d[i*LIVES_W +: LIVES_W] = lives[i*LIVES_W +: LIVES_W] - 4'd1;
          if (lives[i*LIVES_W +: LIVES_W] == 4'd1) alive_d[i] = 1'b0;
        end
      end
    end
    game_end = playing && ((sec_tick && (time_left == 8'd1)) || (alive_d == '0));
  end

  // Lowest-index leader and tie flag over the post-edge scores.
  always_comb begin
    best  = nxt_score[0];
    win_c = '0;
    tie_c = 1'b0;
    for (int i = 1; i < int'(NUM_PLAYERS); i++) begin
      if (nxt_score[i] > best) begin
        best  = nxt_score[i];
        win_c = WIN_W'(i);
        tie_c = 1'b0;
      end else if (nxt_score[i] == best) begin
        tie_c = 1'b1;
      end
    end
  end

  // Winner/tie are captured only on the edge that enters GAME_OVER.
  always_comb begin
    winner_d = winner;
    tie_d    = tie;
    if (clr) begin
      winner_d = '0;
      tie_d    = 1'b0;
    end else if (game_end) begin
      winner_d = win_c;
      tie_d    = tie_c;
    end
  end

  // Next-state logic; game-over outranks pause.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (start) state_d = S_PLAYING;
      S_PLAYING: begin
        if (game_end)   state_d = S_GAME_OVER;
        else if (pause) state_d = S_PAUSED;
      end
      S_PAUSED:    if (pause) state_d = S_PLAYING;
      S_GAME_OVER: if (start) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q    <= '0;
      time_left <= TIME_W'(ROUND_SECONDS);
      for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
        lives[i*LIVES_W +: LIVES_W] <= LIVES_W'(MAX_LIVES);
      end
      alive     <= '1;
      winner    <= '0;
      tie       <= 1'b0;
    end else begin
      fcnt_q    <= fcnt_d;
      time_left <= time_d;
      lives     <= lives_d;
      alive     <= alive_d;
      winner    <= winner_d;
      tie       <= tie_d;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Randomised and directed bench for game_ctrl against a decimal reference model.
module tb_game_ctrl;

  localparam int NP  = 2;
  localparam int SD  = 2;
  localparam int ML  = 3;
  localparam int FPS = 4;
  localparam int RS  = 3;
  localparam int MAX_SCORE = 99;

  localparam int ST_IDLE = 0, ST_PLAY = 1, ST_OVER = 2, ST_PAUSE = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame = 1'b0;
  logic              start = 1'b0;
  logic              pause = 1'b0;
  logic [NP-1:0]     hit = '0;
  logic [NP-1:0]     miss = '0;
  logic [1:0]        state;
  logic [NP*SD*4-1:0] score;
  logic [NP*4-1:0]   lives;
  logic [NP-1:0]     alive;
  logic [7:0]        time_left;
  logic [1:0]        winner;
  logic              tie;

  int checks = 0;
  int errors = 0;

  // Reference model state, kept as plain decimal integers.
  int m_state;
  int m_score [NP];
  int m_lives [NP];
  int m_time;
  int m_fc;
  int m_win;
  int m_tie;

  game_ctrl #(
    .NUM_PLAYERS(NP), .SCORE_DIGITS(SD), .MAX_LIVES(ML),
    .FRAMES_PER_SEC(FPS), .ROUND_SECONDS(RS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame(frame), .start(start), .pause(pause),
    .hit(hit), .miss(miss), .state(state), .score(score), .lives(lives),
    .alive(alive), .time_left(time_left), .winner(winner), .tie(tie)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic model_reset();
    m_state = ST_IDLE;
    m_time  = RS;
    m_fc    = 0;
    m_win   = 0;
    m_tie   = 0;
    for (int i = 0; i < NP; i++) begin
      m_score[i] = 0;
      m_lives[i] = ML;
    end
  endtask

  // Apply one clock edge of the game rules to the model.
  task automatic model_step(input logic st, input logic pa, input logic fr,
                            input logic [NP-1:0] hi, input logic [NP-1:0] mi);
    bit over;
    int any_alive, top, cnt;
    over = 0;
    case (m_state)
      ST_IDLE: if (st) m_state = ST_PLAY;
      ST_PLAY: begin
        if (fr) begin
          m_fc++;
          if (m_fc == FPS) begin
            m_fc = 0;
            m_time--;
            if (m_time == 0) over = 1;
          end
        end
        any_alive = 0;
        for (int i = 0; i < NP; i++) begin
          if (hi[i] && m_lives[i] > 0 && m_score[i] < MAX_SCORE) m_score[i]++;
          if (mi[i] && m_lives[i] > 0) m_lives[i]--;
          if (m_lives[i] > 0) any_alive = 1;
        end
        if (!any_alive) over = 1;
        if (over) begin
          m_state = ST_OVER;
          top = -1; cnt = 0; m_win = 0;
          for (int i = 0; i < NP; i++) begin
            if (m_score[i] > top) begin top = m_score[i]; m_win = i; end
          end
          for (int i = 0; i < NP; i++) if (m_score[i] == top) cnt++;
          m_tie = (cnt > 1) ? 1 : 0;
        end else if (pa) begin
          m_state = ST_PAUSE;
        end
      end
      ST_PAUSE: if (pa) m_state = ST_PLAY;
      default: if (st) model_reset();
    endcase
  endtask

  task automatic check_all();
    logic [NP*SD*4-1:0] es;
    logic [NP*4-1:0]    el;
    logic [NP-1:0]      ea;
    for (int i = 0; i < NP; i++) begin
      es[i*8 +: 8] = to_bcd(m_score[i]);
      el[i*4 +: 4] = 4'(m_lives[i]);
      ea[i]        = (m_lives[i] > 0);
    end
    chk("state", 32'(state), 32'(m_state));
    chk("score", 32'(score), 32'(es));
    chk("lives", 32'(lives), 32'(el));
    chk("alive", 32'(alive), 32'(ea));
    chk("time_left", 32'(time_left), 32'(m_time));
    if (m_state == ST_OVER) begin
      chk("winner", 32'(winner), 32'(m_win));
      chk("tie", 32'(tie), 32'(m_tie));
    end
  endtask

  // Drive one cycle of pulses, step the model on the edge, then compare.
  task automatic cyc(input logic st, input logic pa, input logic fr,
                     input logic [NP-1:0] hi, input logic [NP-1:0] mi);
    start = st; pause = pa; frame = fr; hit = hi; miss = mi;
    @(posedge clk);
    model_step(st, pa, fr, hi, mi);
    #1;
    start = 1'b0; pause = 1'b0; frame = 1'b0; hit = '0; miss = '0;
    check_all();
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    chk("rst_winner", 32'(winner), 32'd0);
    chk("rst_tie", 32'(tie), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Start, then run the round out on frames alone.
    cyc(1, 0, 0, 2'b00, 2'b00);
    chk("start_state", 32'(state), 32'd1);
    for (int k = 0; k < 12; k++) cyc(0, 0, 1, 2'b00, 2'b00);
    chk("timeout_state", 32'(state), 32'd2);
    chk("timeout_time", 32'(time_left), 32'd0);
    cyc(1, 0, 0, 2'b00, 2'b00);

    // Score saturation and lives exhaustion.
    cyc(1, 0, 0, 2'b00, 2'b00);
    for (int k = 0; k < 105; k++) cyc(0, 0, 0, 2'b01, 2'b00);
    chk("sat_score", 32'(score), 32'h0099);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 2'b00, 2'b10);
    chk("alive_after_p1", 32'(alive), 32'b01);
    cyc(0, 0, 0, 2'b10, 2'b10);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 2'b00, 2'b01);
    chk("alldead_state", 32'(state), 32'd2);
    cyc(1, 0, 0, 2'b00, 2'b00);

    // Pause mid-second; the tick must come after the remaining frames.
    cyc(1, 0, 0, 2'b00, 2'b00);
    cyc(0, 0, 1, 2'b00, 2'b00);
    cyc(0, 0, 1, 2'b00, 2'b00);
    cyc(0, 1, 0, 2'b00, 2'b00);
    chk("paused_state", 32'(state), 32'd3);
    for (int k = 0; k < 8; k++) cyc(0, 0, 1, 2'b11, 2'b11);
    cyc(0, 1, 0, 2'b00, 2'b00);
    chk("resumed_state", 32'(state), 32'd1);
    cyc(0, 0, 1, 2'b00, 2'b00);
    chk("resume_one_frame", 32'(time_left), 32'd3);
    cyc(0, 0, 1, 2'b00, 2'b00);
    chk("resume_tick", 32'(time_left), 32'd2);
    for (int k = 0; k < 8; k++) cyc(0, 0, 1, 2'b00, 2'b00);
    cyc(1, 0, 0, 2'b00, 2'b00);

    // Tied scores at timeout, then a clear winner.
    cyc(1, 0, 0, 2'b00, 2'b00);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 2'b11, 2'b00);
    for (int k = 0; k < 12; k++) cyc(0, 0, 1, 2'b00, 2'b00);
    chk("tie_winner", 32'(winner), 32'd0);
    chk("tie_flag", 32'(tie), 32'd1);
    cyc(1, 0, 0, 2'b00, 2'b00);
    cyc(1, 0, 0, 2'b00, 2'b00);
    for (int k = 0; k < 7; k++) cyc(0, 0, 0, {1'b1, (k < 3)}, 2'b00);
    for (int k = 0; k < 12; k++) cyc(0, 0, 1, 2'b00, 2'b00);
    chk("win1_winner", 32'(winner), 32'd1);
    chk("win1_tie", 32'(tie), 32'd0);
    cyc(1, 0, 0, 2'b00, 2'b00);
    chk("restart_idle", 32'(state), 32'd0);
    chk("restart_time", 32'(time_left), 32'd3);

    // Randomised play.
    for (int k = 0; k < 4000; k++) begin
      logic [NP-1:0] hi, mi;
      for (int i = 0; i < NP; i++) begin
        hi[i] = ($urandom_range(0, 3) == 0);
        mi[i] = ($urandom_range(0, 19) == 0);
      end
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 2) == 0), hi, mi);
    end

    // Asynchronous reset between edges in the middle of a game.
    if (m_state == ST_OVER) cyc(1, 0, 0, 2'b00, 2'b00);
    if (m_state == ST_IDLE) cyc(1, 0, 0, 2'b00, 2'b00);
    if (m_state == ST_PAUSE) cyc(0, 1, 0, 2'b00, 2'b00);
    cyc(0, 0, 1, 2'b11, 2'b01);
    cyc(0, 0, 0, 2'b01, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_winner", 32'(winner), 32'd0);
    chk("async_tie", 32'(tie), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Parametrised game-flow controller; next generation of the board-level game FSM.
- Runs IDLE / PLAYING / PAUSED / GAME_OVER for 1..4 players, each with a BCD score and a lives counter.
- Keeps a round countdown timed by the video `frame` pulse.
- Sits between debounced KEY/SW pulse logic and the HEX/LEDR display drivers; all outputs are registered.

Parameters:
- NUM_PLAYERS, 2, number of players (1..4).
- SCORE_DIGITS, 2, BCD digits per player score (1..4).
- MAX_LIVES, 3, lives each player starts with (1..15).
- FRAMES_PER_SEC, 60, frame pulses per countdown second (>=2).
- ROUND_SECONDS, 99, round length in seconds (1..255).

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- frame, in, 1, single-cycle pulse once per video frame.
- start, in, 1, single-cycle pulse; start or restart.
- pause, in, 1, single-cycle pulse; toggles pause.
- hit, in, NUM_PLAYERS, per-player single-cycle score pulse.
- miss, in, NUM_PLAYERS, per-player single-cycle life-loss pulse.
- state, out, 2, current state.
- score, out, NUM_PLAYERS*SCORE_DIGITS*4, packed BCD scores; player 0 in the LSBs.
- lives, out, NUM_PLAYERS*4, packed lives counts; player 0 in the LSBs.
- alive, out, NUM_PLAYERS, player still has lives.
- time_left, out, 8, seconds remaining, binary.
- winner, out, 2, index of the highest scorer; valid in GAME_OVER.
- tie, out, 1, the top score is shared.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, scores=0, lives=MAX_LIVES, alive=all 1, time_left=ROUND_SECONDS.
  - frame counter=0, winner=0, tie=0.
  - Reset mid-game returns to these values immediately.
- State encoding: IDLE=2'b00, PLAYING=2'b01, GAME_OVER=2'b10, PAUSED=2'b11.
- IDLE:
  - Counters held at their reset values.
  - start -> PLAYING on the next edge; hit/miss/pause/frame ignored.
- PLAYING:
  - A frame pulse advances the frame counter, which wraps at FRAMES_PER_SEC-1. The wrap is sec_tick; time_left decrements on sec_tick.
  - hit[i] with alive[i]: score[i] increments in BCD (9->0 with carry).
    - Saturates at all-9s (e.g. 99 stays 99).
    - Ignored when alive[i]=0.
  - miss[i] with lives[i]>0: lives[i] decrements; alive[i] drops on the same edge lives reaches 0. Ignored when lives[i]=0.
  - hit and miss on the same player, same cycle: both applied.
  - -> GAME_OVER on the edge where time_left goes 1->0, or where the last alive player's lives reach 0; either or both -> one transition. Hits/misses in that final cycle are applied.
  - pause -> PAUSED. start is ignored in PLAYING. pause takes effect even in a cycle that also ends the game? No: game-over has priority over pause.
- PAUSED:
  - Frame counter, timer, scores and lives frozen; hit/miss/frame ignored.
  - pause -> PLAYING, resuming the frame count where it stopped. start ignored.
- GAME_OVER:
  - Counters frozen.
  - winner/tie registered on the entry edge:
    - winner = lowest index holding the max score.
    - tie = 1 if two or more players share the max.
    - NUM_PLAYERS=1: winner=0, tie=0.
  - start -> IDLE, reinitialising all counters; a further start is needed to play.
- Latency: every output reflects an input pulse one clock after the sampling edge. Pulses arriving while a transition is in progress are evaluated against the current (pre-edge) state.
- Unused MSBs of winner are 0.

Decomposition:
- Package game_pkg holds:
  - state encodings S_IDLE / S_PLAYING / S_GAME_OVER / S_PAUSED (shared with the display mux).
  - BCD digit width (4).
  - Max player count (4).
- Sub-module bcd_counter (parameter DIGITS; inc, clr, saturating all-9s output) is instanced once per player via generate.
- Frame/second divider and winner compare stay inline.

Test Plan (NUM_PLAYERS=2, SCORE_DIGITS=2, MAX_LIVES=3, FRAMES_PER_SEC=4, ROUND_SECONDS=3):
- Reset then start -> state=01 after 1 clk. Then 12 frame pulses -> time_left 3,2,1,0; state=10 on the edge of the 12th-frame wrap.
- PLAYING, 105 hit[0] pulses -> score[0] reads 09, 10 … 99 and holds at 99; score[1]=00.
- miss[1] x3 -> lives[1]=2,1,0, alive=2'b01. A 4th miss and hit[1] ignored. miss[0] x3 -> state=10 on the third.
- pause, 8 frame pulses, pause -> time_left unchanged across the pause; state 11 then 01. The frame counter resumes mid-second: the tick comes after the remaining frames, not after 4.
- Scores 05/05 at the timeout edge -> winner=0, tie=1. Scores 03/07 -> winner=1, tie=0. Then start -> IDLE, scores 00, lives 3/3, time_left=3.
- Assert rst_n=0 mid-PLAYING (asynchronously, between edges) -> all outputs at reset values immediately, without waiting for clk.
